// File: rtl/burst_ram_pkg.sv
// ============================================================================
//  Module      : burst_ram_pkg
//  Description : Shared constants, arbiter state encoding and defaults for the
//                two-port burst RAM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package burst_ram_pkg;

  localparam int BURST_BEATS = 4;
  localparam int BEAT_CNT_W  = $clog2(BURST_BEATS);

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam int DEFAULT_COMMAND_DELAY_INTERVAL = 13;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WRITE_BEATS = 2'd1,
    ST_READ_WAIT   = 2'd2,
    ST_READ_BEATS  = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/burst_ram_port_buffer.sv
// ============================================================================
//  Module      : burst_ram_port_buffer
//  Description : Single-entry command buffer for one client port: captures
//                cmd/addr and the four write beats, tracks pending and busy.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_ram_port_buffer
  import burst_ram_pkg::*;
#(
  parameter int RAM_DEPTH_BITWIDTH = 21
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cmd_en_i,
  input  logic                               cmd_i,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]      addr_i,
  input  logic [63:0]                        wr_data_i,
  input  logic                               done_i,
  output logic                               pending_o,
  output logic                               busy_o,
  output logic                               cmd_o,
  output logic [RAM_DEPTH_BITWIDTH-1:0]      addr_o,
  output logic [BURST_BEATS-1:0][63:0]       beats_o,
  output logic                               violation_o
);

  logic                              busy_q,    busy_d;
  logic                              pending_q, pending_d;
  logic                              collect_q, collect_d;
  logic [BEAT_CNT_W-1:0]             wcnt_q,    wcnt_d;
  logic                              cmd_q,     cmd_d;
  logic [RAM_DEPTH_BITWIDTH-1:0]     addr_q,    addr_d;
  logic [BURST_BEATS-1:0][63:0]      beats_q,   beats_d;
  logic                              w_capture;

  assign w_capture   = cmd_en_i && !busy_q;
  assign violation_o = cmd_en_i && busy_q;

  always_comb begin
    busy_d    = busy_q;
    pending_d = pending_q;
    collect_d = collect_q;
    wcnt_d    = wcnt_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    beats_d   = beats_q;

    if (w_capture) begin
      busy_d = 1'b1;
      cmd_d  = cmd_i;
      addr_d = addr_i;
      if (cmd_i == CMD_WRITE) begin
        beats_d[0] = wr_data_i;
        collect_d  = 1'b1;
        wcnt_d     = BEAT_CNT_W'(1);
      end else begin
        pending_d = 1'b1;
      end
    end else if (collect_q) begin
      // A write only becomes visible to the arbiter once its last beat is held.
      beats_d[wcnt_q] = wr_data_i;
      wcnt_d          = wcnt_q + BEAT_CNT_W'(1);
      if (wcnt_q == BEAT_CNT_W'(BURST_BEATS - 1)) begin
        collect_d = 1'b0;
        pending_d = 1'b1;
      end
    end

    if (done_i) begin
      pending_d = 1'b0;
      busy_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
      collect_q <= 1'b0;
      wcnt_q    <= '0;
      cmd_q     <= CMD_READ;
      addr_q    <= '0;
      beats_q   <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
      collect_q <= collect_d;
      wcnt_q    <= wcnt_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      beats_q   <= beats_d;
    end
  end

  assign pending_o = pending_q;
  assign busy_o    = busy_q;
  assign cmd_o     = cmd_q;
  assign addr_o    = addr_q;
  assign beats_o   = beats_q;

endmodule

`default_nettype wire

// File: rtl/burst_ram_arbiter.sv
// ============================================================================
//  Module      : burst_ram_arbiter
//  Description : Two-port round-robin arbiter issuing 4-beat bursts to a PSRAM
//                command port with a minimum command spacing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_ram_arbiter
  import burst_ram_pkg::*;
#(
  parameter int RAM_DEPTH_BITWIDTH     = 21,
  parameter int COMMAND_DELAY_INTERVAL = DEFAULT_COMMAND_DELAY_INTERVAL
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          p0_cmd,
  input  logic                          p0_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0] p0_addr,
  input  logic [63:0]                   p0_wr_data,
  output logic [63:0]                   p0_rd_data,
  output logic                          p0_rd_data_valid,
  output logic                          p0_busy,
  input  logic                          p1_cmd,
  input  logic                          p1_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0] p1_addr,
  input  logic [63:0]                   p1_wr_data,
  output logic [63:0]                   p1_rd_data,
  output logic                          p1_rd_data_valid,
  output logic                          p1_busy,
  output logic                          br_cmd,
  output logic                          br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0] br_addr,
  output logic [63:0]                   br_wr_data,
  output logic [7:0]                    br_data_mask,
  input  logic [63:0]                   br_rd_data,
  input  logic                          br_rd_data_valid,
  output logic                          protocol_error
);

  localparam int DLY_W = (COMMAND_DELAY_INTERVAL < 1) ? 1 : $clog2(COMMAND_DELAY_INTERVAL + 1);

  logic [1:0]                    w_cmd_en_in;
  logic [1:0]                    w_cmd_in;
  logic [RAM_DEPTH_BITWIDTH-1:0] w_addr_in [2];
  logic [63:0]                   w_wr_in   [2];

  logic [1:0]                    w_pend;
  logic [1:0]                    w_busy;
  logic [1:0]                    w_cmd;
  logic [1:0]                    w_viol;
  logic [1:0]                    w_done;
  logic [RAM_DEPTH_BITWIDTH-1:0] w_addr  [2];
  logic [BURST_BEATS-1:0][63:0]  w_beats [2];

  arb_state_e             state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   rr_q,    rr_d;
  logic [BEAT_CNT_W-1:0]  beat_q,  beat_d;
  logic [DLY_W-1:0]       dly_q,   dly_d;
  logic                   err_q,   err_d;

  logic w_grant;
  logic w_pick;
  logic w_rd_phase;
  logic w_last_beat;

  assign w_cmd_en_in  = {p1_cmd_en, p0_cmd_en};
  assign w_cmd_in     = {p1_cmd, p0_cmd};
  assign w_addr_in[0] = p0_addr;
  assign w_addr_in[1] = p1_addr;
  assign w_wr_in[0]   = p0_wr_data;
  assign w_wr_in[1]   = p1_wr_data;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    burst_ram_port_buffer #(
      .RAM_DEPTH_BITWIDTH (RAM_DEPTH_BITWIDTH)
    ) u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_en_i    (w_cmd_en_in[gi]),
      .cmd_i       (w_cmd_in[gi]),
      .addr_i      (w_addr_in[gi]),
      .wr_data_i   (w_wr_in[gi]),
      .done_i      (w_done[gi]),
      .pending_o   (w_pend[gi]),
      .busy_o      (w_busy[gi]),
      .cmd_o       (w_cmd[gi]),
      .addr_o      (w_addr[gi]),
      .beats_o     (w_beats[gi]),
      .violation_o (w_viol[gi])
    );
  end

  // rr_q remembers the winner of the last tie only; single-port grants leave it alone.
  assign w_grant     = (state_q == ST_IDLE) && (|w_pend) && (dly_q == '0);
  assign w_pick      = (&w_pend) ? ~rr_q : w_pend[1];
  assign w_rd_phase  = (state_q == ST_READ_WAIT) || (state_q == ST_READ_BEATS);
  assign w_last_beat = (beat_q == BEAT_CNT_W'(BURST_BEATS - 1));

  assign br_cmd_en    = w_grant;
  assign br_cmd       = w_grant ? w_cmd[w_pick] : CMD_READ;
  assign br_addr      = w_grant ? w_addr[w_pick] : '0;
  assign br_data_mask = 8'h00;

  always_comb begin
    br_wr_data = '0;
    if (w_grant && (w_cmd[w_pick] == CMD_WRITE)) begin
      br_wr_data = w_beats[w_pick][0];
    end else if (state_q == ST_WRITE_BEATS) begin
      br_wr_data = w_beats[owner_q][beat_q];
    end
  end

  assign p0_rd_data       = br_rd_data;
  assign p1_rd_data       = br_rd_data;
  assign p0_rd_data_valid = br_rd_data_valid && w_rd_phase && (owner_q == 1'b0);
  assign p1_rd_data_valid = br_rd_data_valid && w_rd_phase && (owner_q == 1'b1);
  assign p0_busy          = w_busy[0];
  assign p1_busy          = w_busy[1];
  assign protocol_error   = err_q;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    dly_d   = (dly_q != '0) ? dly_q - DLY_W'(1) : dly_q;
    w_done  = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (w_grant) begin
          owner_d = w_pick;
          dly_d   = DLY_W'(COMMAND_DELAY_INTERVAL);
          if (&w_pend) begin
            rr_d = w_pick;
          end
          if (w_cmd[w_pick] == CMD_WRITE) begin
            beat_d  = BEAT_CNT_W'(1);
            state_d = ST_WRITE_BEATS;
          end else begin
            beat_d  = '0;
            state_d = ST_READ_WAIT;
          end
        end
      end
      ST_WRITE_BEATS: begin
        beat_d = beat_q + BEAT_CNT_W'(1);
        if (w_last_beat) begin
          w_done[owner_q] = 1'b1;
          state_d         = ST_IDLE;
        end
      end
      ST_READ_WAIT: begin
        if (br_rd_data_valid) begin
          beat_d  = BEAT_CNT_W'(1);
          state_d = ST_READ_BEATS;
        end
      end
      ST_READ_BEATS: begin
        if (br_rd_data_valid) begin
          beat_d = beat_q + BEAT_CNT_W'(1);
          if (w_last_beat) begin
            w_done[owner_q] = 1'b1;
            state_d         = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    err_d = err_q || (|w_viol) || (br_rd_data_valid && !w_rd_phase);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b1;
      beat_q  <= '0;
      dly_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      dly_q   <= dly_d;
      err_q   <= err_d;
    end
  end

endmodule

`default_nettype wire
